// File: rtl/ff_pkg.sv
// Shared definitions for the force-format line receiver.
//   - line format codes carried on the FF bus
//   - HUNT/DATA state encoding of the receive FSM
//   - man_expand(): Manchester expansion of a byte, MSB first (1 -> 10, 0 -> 01)
package ff_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MAN_W  = 2 * BYTE_W;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] FF_NRZ     = 2'b00;
    localparam logic [1:0] FF_NRZ_INV = 2'b01;
    localparam logic [1:0] FF_MAN     = 2'b10;
    localparam logic [1:0] FF_FORCE   = 2'b11;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_e;

    // Each data bit becomes a half-bit pair; bit 7 lands in the top pair.
    function automatic logic [MAN_W-1:0] man_expand(input logic [BYTE_W-1:0] b);
        logic [MAN_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            r[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/ff_man_pair.sv
// Manchester half-bit pair assembler.
// Collects two consecutive enabled samples into one decoded bit.
//   clk, rst     : clock, synchronous active-high reset
//   sample_en    : take `sample` this cycle
//   sample       : raw line sample
//   phase_clr    : force the next enabled sample to be a first half
//   bit_valid_c  : combinational, second half taken this cycle
//   bit_c        : combinational, decoded bit (pair 10 -> 1, 01 -> 0)
//   viol_c       : combinational, pair was 00 or 11
module ff_man_pair (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic sample,
    input  logic phase_clr,
    output logic bit_valid_c,
    output logic bit_c,
    output logic viol_c
);

    logic phase_q, phase_d;
    logic half_q, half_d;

    // Phase 0 stores the first half; phase 1 completes the pair.
    always_comb begin
        phase_d     = phase_q;
        half_d      = half_q;
        bit_valid_c = 1'b0;
        bit_c       = half_q;
        viol_c      = 1'b0;
        if (phase_clr) begin
            phase_d = 1'b0;
        end else if (sample_en) begin
            if (!phase_q) begin
                half_d  = sample;
                phase_d = 1'b1;
            end else begin
                bit_valid_c = 1'b1;
                viol_c      = (half_q == sample);
                phase_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
        end
    end

endmodule

// File: rtl/ff_rx_deser.sv
// Serial receiver/deserializer for the force-format line.
// Samples LINE_IN on CLK_ENABLE, decodes per FF (NRZ, inverted NRZ,
// Manchester, forced), hunts for SYNC_WORD, then delivers FRAME_BYTES bytes.
//   CLK, RST    : clock, synchronous active-high reset
//   CLK_ENABLE  : line sample strobe
//   LINE_IN     : serial line
//   FF          : format code
//   DATA_OUT    : last received byte
//   DATA_VALID  : one-cycle pulse per byte
//   SYNC_LOCK   : high while in DATA
//   FORMAT_ERR  : one-cycle pulse on a Manchester violation in DATA
//   FORCE_DET   : line stuck detector (FF_RX_FORCE_DET_EN); tied 0 otherwise
module ff_rx_deser
    import ff_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD   = 8'hA5,
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned STUCK_LEN   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_ENABLE,
    input  logic       LINE_IN,
    input  logic [1:0] FF,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       SYNC_LOCK,
    output logic       FORMAT_ERR,
    output logic       FORCE_DET
);

    localparam logic [MAN_W-1:0] SYNC_MAN  = man_expand(SYNC_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    if (FRAME_BYTES < 1 || FRAME_BYTES > 255 || STUCK_LEN < 2 || STUCK_LEN > 255) begin : g_param_check
        $error("ff_rx_deser: FRAME_BYTES or STUCK_LEN out of range");
    end

    state_e              state_q, state_d;
    logic [MAN_W-1:0]    shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                format_err_q, format_err_d;
    logic                sync_lock_q, sync_lock_d;
    logic [1:0]          ff_prev_q, ff_prev_d;

    logic                ff_change;
    logic                nrz_bit;
    logic                man_en;
    logic                man_clr;
    logic                man_valid_c, man_bit_c, man_viol_c;
    logic [MAN_W-1:0]    hunt_shift;
    logic [BYTE_W-1:0]   byte_w;
    logic                rx_bit;
    logic                take_bit;

    assign ff_change = (FF != ff_prev_q);
    assign nrz_bit   = (FF == FF_NRZ_INV) ? ~LINE_IN : LINE_IN;

    // Pair phase is pinned while hunting so the sync match fixes it.
    assign man_en  = CLK_ENABLE && (FF == FF_MAN) && (state_q == DATA) && !ff_change;
    assign man_clr = (state_q == HUNT) || ff_change;

    ff_man_pair u_man_pair (
        .clk         (CLK),
        .rst         (RST),
        .sample_en   (man_en),
        .sample      (LINE_IN),
        .phase_clr   (man_clr),
        .bit_valid_c (man_valid_c),
        .bit_c       (man_bit_c),
        .viol_c      (man_viol_c)
    );

    // Sync hunt, byte assembly and frame sequencing.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        format_err_d = 1'b0;
        ff_prev_d    = FF;
        hunt_shift   = '0;
        byte_w       = '0;
        rx_bit       = 1'b0;
        take_bit     = 1'b0;

        if (ff_change) begin
            // Format switch drops any frame in progress silently.
            state_d    = HUNT;
            shift_d    = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (CLK_ENABLE) begin
            case (state_q)
                HUNT: begin
                    if (FF == FF_MAN) begin
                        hunt_shift = {shift_q[MAN_W-2:0], LINE_IN};
                        shift_d    = hunt_shift;
                        if (hunt_shift == SYNC_MAN) begin
                            state_d = DATA;
                            shift_d = '0;
                        end
                    end else if (FF != FF_FORCE) begin
                        hunt_shift = {shift_q[MAN_W-2:0], nrz_bit};
                        shift_d    = hunt_shift;
                        if (hunt_shift[BYTE_W-1:0] == SYNC_WORD) begin
                            state_d = DATA;
                            shift_d = '0;
                        end
                    end
                end
                DATA: begin
                    if (FF == FF_MAN) begin
                        rx_bit   = man_bit_c;
                        take_bit = man_valid_c && !man_viol_c;
                        if (man_viol_c) begin
                            format_err_d = 1'b1;
                            state_d      = HUNT;
                            shift_d      = '0;
                            bit_cnt_d    = '0;
                            byte_cnt_d   = '0;
                        end
                    end else begin
                        rx_bit   = nrz_bit;
                        take_bit = 1'b1;
                    end
                    if (take_bit) begin
                        byte_w    = {shift_q[BYTE_W-2:0], rx_bit};
                        shift_d   = {BYTE_W'(0), byte_w};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_out_d   = byte_w;
                            data_valid_d = 1'b1;
                            shift_d      = '0;
                            if (byte_cnt_q == LAST_BYTE) begin
                                state_d    = HUNT;
                                byte_cnt_d = '0;
                            end else begin
                                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        sync_lock_d = (state_d == DATA);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            format_err_q <= 1'b0;
            sync_lock_q  <= 1'b0;
            ff_prev_q    <= FF_NRZ;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            format_err_q <= format_err_d;
            sync_lock_q  <= sync_lock_d;
            ff_prev_q    <= ff_prev_d;
        end
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_VALID = data_valid_q;
    assign SYNC_LOCK  = sync_lock_q;
    assign FORMAT_ERR = format_err_q;

`ifdef FF_RX_FORCE_DET_EN
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_LEN - 1);

    logic             prev_sample_q, prev_sample_d;
    logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic             force_det_q, force_det_d;

    // Run length of identical raw samples, saturating at STUCK_MAX.
    always_comb begin
        prev_sample_d = prev_sample_q;
        stuck_cnt_d   = stuck_cnt_q;
        force_det_d   = force_det_q;
        if (CLK_ENABLE) begin
            prev_sample_d = LINE_IN;
            if (LINE_IN == prev_sample_q) begin
                if (stuck_cnt_q < STUCK_MAX) begin
                    stuck_cnt_d = stuck_cnt_q + CNT_W'(1);
                end
            end else begin
                stuck_cnt_d = '0;
            end
            force_det_d = (stuck_cnt_d == STUCK_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_sample_q <= 1'b0;
            stuck_cnt_q   <= '0;
            force_det_q   <= 1'b0;
        end else begin
            prev_sample_q <= prev_sample_d;
            stuck_cnt_q   <= stuck_cnt_d;
            force_det_q   <= force_det_d;
        end
    end

    assign FORCE_DET = force_det_q;
`else
    assign FORCE_DET = 1'b0;
`endif

endmodule
